// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and load/store share one memory port,
// one transaction in flight, data-first priority with a bounded fetch starvation window.
module mem_arb #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   input  logic [63:0] if_req_addr,
   output logic        if_req_ready,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_instr,
   input  logic        d_req_valid,
   input  logic        d_req_we,
   input  logic [63:0] d_req_addr,
   input  logic [63:0] d_req_wdata,
   input  logic [1:0]  d_req_len,
   output logic        d_req_ready,
   output logic        d_rsp_valid,
   output logic [63:0] d_rsp_rdata,
   output logic        mem_req_valid,
   output logic        mem_req_we,
   output logic [63:0] mem_req_addr,
   output logic [63:0] mem_req_wdata,
   output logic [1:0]  mem_req_len,
   input  logic        mem_req_ready,
   input  logic        mem_rsp_valid,
   input  logic [63:0] mem_rsp_data,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

   localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

   state_t     state_q, state_d;
   logic [2:0] starve_q, starve_d;
   logic       we_q, we_d;
   logic       a2_q, a2_d;
   logic       err_q, err_d;

   logic       idle;
   logic       fetch_due;
   logic       grant_d;
   logic       grant_if;
   logic       hs;

   // Gating with rst keeps every valid/ready low while reset is held.
   assign idle      = rst && (state_q == IDLE);
   assign fetch_due = if_req_valid && (starve_q == STARVE_LIM);
   assign grant_d   = idle && d_req_valid && !fetch_due;
   assign grant_if  = idle && if_req_valid && !grant_d;
   assign hs        = (grant_d || grant_if) && mem_req_ready;

   assign mem_req_valid = grant_d || grant_if;
   assign mem_req_we    = grant_d && d_req_we;
   assign mem_req_addr  = grant_if ? if_req_addr : d_req_addr;
   assign mem_req_wdata = grant_d ? d_req_wdata : 64'h0;
   assign mem_req_len   = grant_if ? 2'd2 : d_req_len;

   assign if_req_ready = grant_if && mem_req_ready;
   assign d_req_ready  = grant_d && mem_req_ready;

   assign if_rsp_valid = rst && (state_q == WAIT_IF) && mem_rsp_valid;
   assign if_rsp_instr = !if_rsp_valid ? 32'h0 :
                         (a2_q ? mem_rsp_data[63:32] : mem_rsp_data[31:0]);
   assign d_rsp_valid  = rst && (state_q == WAIT_D) && mem_rsp_valid;
   assign d_rsp_rdata  = (d_rsp_valid && !we_q) ? mem_rsp_data : 64'h0;

   assign err = err_q;

   always_comb begin
      state_d  = state_q;
      starve_d = starve_q;
      we_d     = we_q;
      a2_d     = a2_q;
      err_d    = err_q;
      case (state_q)
         IDLE: begin
            // A response with nothing outstanding is a protocol violation; it is dropped.
            if (mem_rsp_valid) begin
               err_d = 1'b1;
            end
            if (hs) begin
               state_d = grant_d ? WAIT_D : WAIT_IF;
               we_d    = grant_d && d_req_we;
               a2_d    = mem_req_addr[2];
               if (grant_d && if_req_valid) begin
                  starve_d = (starve_q == STARVE_LIM) ? starve_q : 3'(starve_q + 3'd1);
               end else begin
                  starve_d = 3'd0;
               end
            end
         end
         WAIT_IF, WAIT_D: begin
            if (mem_rsp_valid) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         starve_q <= 3'd0;
         we_q     <= 1'b0;
         a2_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         we_q     <= we_d;
         a2_q     <= a2_d;
         err_q    <= err_d;
      end
   end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the arbiter.
module tb_mem_arb;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        if_req_valid, if_req_ready, if_rsp_valid;
   logic [63:0] if_req_addr;
   logic [31:0] if_rsp_instr;
   logic        d_req_valid, d_req_we, d_req_ready, d_rsp_valid;
   logic [63:0] d_req_addr, d_req_wdata, d_rsp_rdata;
   logic [1:0]  d_req_len;
   logic        mem_req_valid, mem_req_we, mem_req_ready, mem_rsp_valid, err;
   logic [63:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
   logic [1:0]  mem_req_len;

   always #5 clk = ~clk;

   mem_arb #(.STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
      .if_rsp_valid(if_rsp_valid), .if_rsp_instr(if_rsp_instr),
      .d_req_valid(d_req_valid), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
      .d_req_wdata(d_req_wdata), .d_req_len(d_req_len), .d_req_ready(d_req_ready),
      .d_rsp_valid(d_rsp_valid), .d_rsp_rdata(d_rsp_rdata),
      .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
      .mem_req_wdata(mem_req_wdata), .mem_req_len(mem_req_len), .mem_req_ready(mem_req_ready),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .err(err)
   );

   int n_vec = 0;
   int n_fail = 0;

   // Transaction-level model: one outstanding request, who owns it, and the starvation run.
   bit m_busy = 0, m_own_d = 0, m_we = 0, m_a2 = 0, m_err = 0;
   int m_cnt = 0;
   bit e_win_d, e_win_if, e_hs;
   bit glog[$];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_check();
      bit ev, edv, eifv, ee;
      logic [31:0] ei;
      logic [63:0] ed;
      edv = 0; eifv = 0; ee = 0; ei = '0; ed = '0;
      e_win_d = 0; e_win_if = 0;
      if (rst) begin
         if (!m_busy) begin
            e_win_d  = d_req_valid && !(if_req_valid && m_cnt >= SM);
            e_win_if = if_req_valid && !e_win_d;
         end else if (mem_rsp_valid) begin
            if (m_own_d) begin
               edv = 1;
               ed  = m_we ? 64'h0 : mem_rsp_data;
            end else begin
               eifv = 1;
               ei   = m_a2 ? mem_rsp_data[63:32] : mem_rsp_data[31:0];
            end
         end
         ee = m_err;
      end
      ev   = e_win_d || e_win_if;
      e_hs = ev && mem_req_ready;
      chk("mem_req_valid", mem_req_valid, ev);
      chk("if_req_ready", if_req_ready, e_win_if && mem_req_ready);
      chk("d_req_ready", d_req_ready, e_win_d && mem_req_ready);
      chk("if_rsp_valid", if_rsp_valid, eifv);
      chk("d_rsp_valid", d_rsp_valid, edv);
      chk("if_rsp_instr", if_rsp_instr, ei);
      chk("d_rsp_rdata", d_rsp_rdata, ed);
      chk("err", err, ee);
      if (ev) begin
         chk("mem_req_addr", mem_req_addr, e_win_d ? d_req_addr : if_req_addr);
         chk("mem_req_we", mem_req_we, e_win_d && d_req_we);
         chk("mem_req_len", mem_req_len, e_win_d ? d_req_len : 2'd2);
         chk("mem_req_wdata", mem_req_wdata, e_win_d ? d_req_wdata : 64'h0);
      end
   endtask

   task automatic model_update();
      bit was_busy;
      if (!rst) begin
         m_busy = 0; m_own_d = 0; m_we = 0; m_a2 = 0; m_err = 0; m_cnt = 0;
      end else begin
         was_busy = m_busy;
         if (mem_rsp_valid && !was_busy) m_err = 1;
         if (mem_rsp_valid && was_busy) m_busy = 0;
         if (e_hs) begin
            m_busy  = 1;
            m_own_d = e_win_d;
            m_we    = e_win_d && d_req_we;
            m_a2    = e_win_d ? d_req_addr[2] : if_req_addr[2];
            glog.push_back(e_win_d);
            if (e_win_if) m_cnt = 0;
            else if (if_req_valid) m_cnt = (m_cnt + 1 > SM) ? SM : m_cnt + 1;
            else m_cnt = 0;
         end
      end
   endtask

   // Called at posedge+1: sample at posedge+4, well away from both edges.
   task automatic settle();
      #3;
      model_check();
   endtask

   task automatic adv();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      if_req_valid = 0; if_req_addr = '0;
      d_req_valid = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_len = '0;
      mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = '0;
   endtask

   initial begin
      logic [9:0] dut_seq, mod_seq;
      bit fh, dh, hs_last, pend;
      int lat, gbase;

      idle_inputs();
      if_req_valid = 1; d_req_valid = 1; mem_rsp_valid = 1;
      @(posedge clk);
      #1;

      // Reset held: everything quiet even with all inputs asserted.
      settle();
      chk("rst_mem_valid", mem_req_valid, 1'b0);
      chk("rst_d_ready", d_req_ready, 1'b0);
      chk("rst_err", err, 1'b0);
      adv();
      idle_inputs();
      rst = 1;

      // Lone fetch to 0x1004, response next cycle selects upper word.
      if_req_valid = 1; if_req_addr = 64'h1004;
      settle();
      chk("f_mem_valid", mem_req_valid, 1'b1);
      chk("f_addr", mem_req_addr, 64'h1004);
      chk("f_len", mem_req_len, 2'd2);
      chk("f_ready", if_req_ready, 1'b1);
      adv();
      if_req_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 64'hAABBCCDD_11223344;
      settle();
      chk("f_rsp_valid", if_rsp_valid, 1'b1);
      chk("f_instr", if_rsp_instr, 32'hAABBCCDD);
      chk("f_wait_noreq", mem_req_valid, 1'b0);
      adv();
      mem_rsp_valid = 0;
      settle();
      chk("f_rsp_once", if_rsp_valid, 1'b0);
      adv();

      // Both requesters always valid, zero-latency memory: starvation pattern.
      if_req_valid = 1; if_req_addr = 64'h4000;
      d_req_valid = 1; d_req_addr = 64'h3000; d_req_len = 2'd3;
      dut_seq = '0;
      gbase = glog.size();
      for (int c = 0; c < 20; c++) begin
         mem_rsp_valid = m_busy;
         mem_rsp_data  = {$urandom, $urandom};
         settle();
         if (d_req_ready) dut_seq = {dut_seq[8:0], 1'b1};
         else if (if_req_ready) dut_seq = {dut_seq[8:0], 1'b0};
         adv();
      end
      chk("order_dut", dut_seq, 10'b1111011110);
      mod_seq = '0;
      for (int i = gbase; i < glog.size(); i++) mod_seq = {mod_seq[8:0], glog[i]};
      chk("order_model", mod_seq, 10'b1111011110);
      idle_inputs();

      // Store held off by memory for three cycles.
      d_req_valid = 1; d_req_we = 1; d_req_addr = 64'h2000; d_req_wdata = 64'hDEAD;
      d_req_len = 2'd3; mem_req_ready = 0;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("st_hold_valid", mem_req_valid, 1'b1);
         chk("st_hold_ready", d_req_ready, 1'b0);
         adv();
      end
      mem_req_ready = 1;
      settle();
      chk("st_ready", d_req_ready, 1'b1);
      chk("st_wdata", mem_req_wdata, 64'hDEAD);
      chk("st_we", mem_req_we, 1'b1);
      adv();
      d_req_valid = 0;
      mem_rsp_valid = 1; mem_rsp_data = 64'h0123_4567_89AB_CDEF;
      settle();
      chk("st_rsp_valid", d_rsp_valid, 1'b1);
      chk("st_rdata", d_rsp_rdata, 64'h0);
      adv();
      idle_inputs();

      // Stray response while idle.
      mem_rsp_valid = 1; mem_rsp_data = 64'h5555;
      settle();
      chk("stray_no_if_rsp", if_rsp_valid, 1'b0);
      chk("stray_no_d_rsp", d_rsp_valid, 1'b0);
      adv();
      mem_rsp_valid = 0;
      for (int c = 0; c < 3; c++) begin
         settle();
         chk("err_sticky", err, 1'b1);
         adv();
      end
      rst = 0;
      settle();
      chk("err_cleared", err, 1'b0);
      adv();
      rst = 1;

      // Reset asserted mid-transaction (WAIT_D) takes effect without a clock.
      d_req_valid = 1; d_req_addr = 64'h2008; d_req_len = 2'd2;
      settle();
      adv();
      settle();
      chk("waitd_noreq", mem_req_valid, 1'b0);
      adv();
      mem_rsp_valid = 1; mem_rsp_data = 64'h77;
      #1 rst = 0;
      #1;
      chk("ar_d_rsp", d_rsp_valid, 1'b0);
      chk("ar_mem_valid", mem_req_valid, 1'b0);
      chk("ar_d_ready", d_req_ready, 1'b0);
      chk("ar_err", err, 1'b0);
      #1;
      model_check();
      adv();
      idle_inputs();
      settle();
      adv();
      rst = 1;
      settle();
      adv();
      mem_rsp_valid = 1;
      settle();
      chk("late_rsp_dropped", d_rsp_valid, 1'b0);
      adv();
      mem_rsp_valid = 0;
      settle();
      chk("late_rsp_err", err, 1'b1);
      adv();
      rst = 0;
      settle();
      adv();
      rst = 1;

      // Randomized traffic with random memory stalls and latency.
      fh = 0; dh = 0; hs_last = 0; pend = 0; lat = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!if_req_valid || fh) begin
            if_req_valid = ($urandom % 3) != 0;
            if_req_addr  = {$urandom, $urandom} & ~64'h3;
         end
         if (!d_req_valid || dh) begin
            d_req_valid = ($urandom % 3) != 0;
            d_req_we    = 1'($urandom % 2);
            d_req_addr  = {$urandom, $urandom};
            d_req_wdata = {$urandom, $urandom};
            d_req_len   = 2'($urandom % 4);
         end
         mem_req_ready = ($urandom % 4) != 0;
         if (hs_last) begin
            pend = 1;
            lat  = $urandom % 3;
         end
         mem_rsp_valid = 0;
         mem_rsp_data  = {$urandom, $urandom};
         if (pend) begin
            if (lat == 0) begin
               mem_rsp_valid = 1;
               pend = 0;
            end else begin
               lat--;
            end
         end
         settle();
         fh = e_hs && e_win_if;
         dh = e_hs && e_win_d;
         hs_last = e_hs;
         adv();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 4: max consecutive data grants while a fetch is pending.
REQ-002 clk  input  1  clock; all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 if_req_valid  input  1  fetch request pending.
REQ-005 if_req_addr  input  64  fetch byte address.
REQ-006 if_req_ready  output  1  fetch request accepted this cycle.
REQ-007 if_rsp_valid  output  1  fetch response pulse.
REQ-008 if_rsp_instr  output  32  fetched instruction.
REQ-009 d_req_valid  input  1  load/store request pending.
REQ-010 d_req_we  input  1  1 = store, 0 = load.
REQ-011 d_req_addr  input  64  data byte address.
REQ-012 d_req_wdata  input  64  store data.
REQ-013 d_req_len  input  2  access size: 0 byte, 1 half, 2 word, 3 double.
REQ-014 d_req_ready  output  1  data request accepted this cycle.
REQ-015 d_rsp_valid  output  1  data response pulse (loads and stores).
REQ-016 d_rsp_rdata  output  64  load data.
REQ-017 mem_req_valid / mem_req_we / mem_req_addr(64) / mem_req_wdata(64) / mem_req_len(2)  outputs  shared memory request.
REQ-018 mem_req_ready  input  1  memory accepts request.
REQ-019 mem_rsp_valid  input  1  memory response, exactly one per accepted request.
REQ-020 mem_rsp_data  input  64  memory read data.
REQ-021 err  output  1  sticky protocol error flag.

Function
REQ-022 FSM states IDLE, WAIT_IF, WAIT_D; one outstanding memory transaction max.
REQ-023 IDLE: winner = data if d_req_valid, unless if_req_valid and starve_cnt == STARVE_MAX, then fetch; fetch if only if_req_valid.
REQ-024 IDLE: mem_req_* = winner's fields combinationally (fetch: we=0, len=2, wdata=0); mem_req_valid = winner exists.
REQ-025 Winner's ready = mem_req_ready in IDLE; loser's ready = 0; both 0 outside IDLE.
REQ-026 Handshake (mem_req_valid & mem_req_ready) -> next state WAIT_IF or WAIT_D; registers owner we flag and addr[2].
REQ-027 No handshake -> stay IDLE, re-arbitrate next cycle; requester holds fields stable while valid.
REQ-028 WAIT_x: mem_req_valid = 0; on mem_rsp_valid, owner rsp_valid = 1 same cycle (combinational), next state IDLE.
REQ-029 Earliest next request: cycle after response (2-cycle minimum per transaction at zero memory latency).
REQ-030 if_rsp_instr = mem_rsp_data[31:0] if registered addr[2]=0, else [63:32].
REQ-031 d_rsp_rdata = mem_rsp_data for loads, 64'h0 for stores; non-owner rsp outputs 0.
REQ-032 starve_cnt (3 bits): +1 on data grant with if_req_valid high; cleared on fetch grant or data grant with if_req_valid low; saturates at STARVE_MAX.
REQ-033 mem_rsp_valid in IDLE -> err set to 1, response dropped, no rsp_valid pulse.
REQ-034 err cleared only by reset.

Reset
REQ-035 rst low: state IDLE, starve_cnt 0, err 0, registered owner flags 0, immediately (asynchronous).
REQ-036 During reset all valid/ready outputs 0; reset mid-transaction abandons it, no response pulse.
REQ-037 Exit from reset: first arbitration on first rising edge with rst high.

Verification
REQ-038 Fetch only, addr 0x1004, mem ready, rsp data 0xAABBCCDD_11223344 next cycle -> if_rsp_instr 0xAABBCCDD, WAIT_IF one cycle.
REQ-039 Fetch and load both valid, starve_cnt 0 -> data granted first; fetch granted after.
REQ-040 Both valid continuously, STARVE_MAX 4 -> grant order D,D,D,D,IF,D,D,D,D,IF.
REQ-041 Store 0xDEAD to 0x2000 len 3, mem_req_ready low 3 cycles -> mem_req_valid held 3 cycles, d_req_ready 0, on 4th cycle handshake; d_rsp_rdata 0 at response.
REQ-042 mem_rsp_valid pulsed in IDLE -> err 1, no rsp pulses, err remains 1 until rst low.
REQ-043 rst low in WAIT_D -> state IDLE, all outputs 0 asynchronously; later stray response sets err.
